// File: rtl/render_pkg.sv
// render_pkg: shared state type, screen defaults and clip helper for the particle render path
package render_pkg;
   typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} render_state_t;
   localparam int DEF_SCREEN_W = 320;
   localparam int DEF_SCREEN_H = 180;
   localparam logic [7:0] DEF_BG = 8'h00;
   localparam logic [7:0] DEF_FG = 8'hFF;
   function automatic logic in_range(input logic [31:0] v, input int lim);
      return $signed(v) >= 0 && $signed(v) < lim;
   endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO with occupancy count; push and pop may coincide when full or empty
module result_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign do_pop = pop && count != '0;
   assign do_push = push && (count != CW'(DEPTH) || do_pop);
   assign dout = mem[rp];
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk_in)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/particle_render_scheduler.sv
// particle_render_scheduler: clears the framebuffer, streams particles through the screen
// transform and plots every on-screen result as a foreground pixel.
module particle_render_scheduler
   import render_pkg::*;
#(
   parameter int NUM_PARTICLES = 64,
   parameter int PADDR_WIDTH = $clog2(NUM_PARTICLES),
   parameter int RD_LATENCY = 2,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   parameter int FB_ADDR_WIDTH = 16,
   parameter int PIXEL_WIDTH = 8,
   parameter logic [PIXEL_WIDTH-1:0] BG_COLOR = PIXEL_WIDTH'(DEF_BG),
   parameter logic [PIXEL_WIDTH-1:0] FG_COLOR = PIXEL_WIDTH'(DEF_FG),
   parameter int FIFO_DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     frame_done,
   output logic [15:0]              dropped_count,
   output logic [PADDR_WIDTH-1:0]   pmem_addr,
   output logic                     pmem_rd_en,
   input  logic [31:0]              pmem_data,
   output logic [31:0]              xf_f,
   output logic                     xf_valid_in,
   input  logic [63:0]              xf_result,
   input  logic                     xf_valid_out,
   output logic [FB_ADDR_WIDTH-1:0] fb_addr,
   output logic [PIXEL_WIDTH-1:0]   fb_data,
   output logic                     fb_we,
   input  logic                     fb_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [FB_ADDR_WIDTH-1:0] LAST_PIX = FB_ADDR_WIDTH'(SCREEN_W * SCREEN_H - 1);
   localparam logic [PADDR_WIDTH-1:0] LAST_IDX = PADDR_WIDTH'(NUM_PARTICLES - 1);

   render_state_t state, state_nxt;
   logic [FB_ADDR_WIDTH-1:0] clr_addr, pix;
   logic [PADDR_WIDTH-1:0] idx;
   logic [CW-1:0] inflight, fifo_count;
   logic [RD_LATENCY-1:0] rd_vld;
   logic [63:0] head, stg;
   logic stg_vld, active, accept, issue, pop, hit, stg_free, clr_xfer;

   // Credits cover both reads still in the transform and results parked in the FIFO,
   // so a non-stallable result always has a slot.
   assign active = state == ISSUE || state == DRAIN;
   assign accept = active && xf_valid_out;
   assign issue = state == ISSUE && 32'(inflight) + 32'(fifo_count) < 32'(FIFO_DEPTH);
   assign hit = stg_vld && in_range(stg[63:32], SCREEN_W) && in_range(stg[31:0], SCREEN_H);
   assign stg_free = !hit || fb_ready;
   assign pop = active && fifo_count != '0 && stg_free;
   assign pix = FB_ADDR_WIDTH'(stg[31:0] * 32'(SCREEN_W) + stg[63:32]);
   assign clr_xfer = state == CLEAR && fb_ready;

   assign pmem_rd_en = issue;
   assign pmem_addr = issue ? idx : '0;
   assign xf_valid_in = rd_vld[RD_LATENCY-1];
   assign xf_f = xf_valid_in ? pmem_data : '0;
   assign busy = state == CLEAR || active;
   assign frame_done = state == DONE;
   assign fb_we = state == CLEAR || hit;
   assign fb_addr = state == CLEAR ? clr_addr : hit ? pix : '0;
   assign fb_data = state == CLEAR ? BG_COLOR : hit ? FG_COLOR : '0;

   result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_fifo (
      .clk_in(clk_in),
      .rst(rst),
      .push(accept),
      .pop(pop),
      .din(xf_result),
      .dout(head),
      .count(fifo_count)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CLEAR;
         CLEAR:   if (clr_xfer && clr_addr == LAST_PIX) state_nxt = ISSUE;
         ISSUE:   if (issue && idx == LAST_IDX) state_nxt = DRAIN;
         DRAIN:   if (inflight == '0 && fifo_count == '0 && !stg_vld) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         state <= IDLE;
         clr_addr <= '0;
         idx <= '0;
         inflight <= '0;
         rd_vld <= '0;
         stg <= '0;
         stg_vld <= 1'b0;
         dropped_count <= '0;
      end else begin
         state <= state_nxt;
         rd_vld <= RD_LATENCY'({rd_vld, issue});
         inflight <= inflight + CW'(issue) - CW'(accept);
         if (clr_xfer) clr_addr <= clr_addr + FB_ADDR_WIDTH'(1);
         if (issue) idx <= idx + PADDR_WIDTH'(1);
         if (pop) stg <= head;
         if (stg_free) stg_vld <= pop;
         if (stg_vld && !hit && dropped_count != '1) dropped_count <= dropped_count + 16'd1;
         if (state == IDLE && start) begin
            clr_addr <= '0;
            idx <= '0;
            dropped_count <= '0;
         end
      end
endmodule

// File: doc/particle_render_scheduler.md
# particle_render_scheduler

Frame-level controller that sequences the particle-to-screen rendering path. On `start` it clears the framebuffer to a background colour, then streams every particle position from particle memory into the binary16 screen-transform pipeline. Each returned screen coordinate is clipped and written to the framebuffer as a foreground pixel. A credit counter and a small result FIFO absorb the transform pipeline's lack of backpressure, so framebuffer stalls never lose a result.

## Interface
Parameters:
- `NUM_PARTICLES`, 64: particles per frame, read from addresses 0..NUM_PARTICLES-1.
- `PADDR_WIDTH`, $clog2(NUM_PARTICLES): particle memory address width.
- `RD_LATENCY`, 2: particle memory read latency in cycles.
- `SCREEN_W`, 320: screen width in pixels.
- `SCREEN_H`, 180: screen height in pixels.
- `FB_ADDR_WIDTH`, 16: framebuffer address width; must hold SCREEN_W*SCREEN_H-1.
- `PIXEL_WIDTH`, 8: framebuffer data width.
- `BG_COLOR`, 8'h00: colour written during clear.
- `FG_COLOR`, 8'hFF: colour written for each particle.
- `FIFO_DEPTH`, 8: result FIFO depth and in-flight credit limit; power of two.

Ports:
- `clk_in` in 1: single clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a frame. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `frame_done`.
- `frame_done` out 1: one-cycle pulse at frame end.
- `dropped_count` out 16: particles clipped in the last frame; cleared on `start`.
- `pmem_addr` out PADDR_WIDTH: particle memory read address.
- `pmem_rd_en` out 1: read strobe.
- `pmem_data` in 2×16: binary16 position {x, y}; data is valid RD_LATENCY cycles after `pmem_rd_en`.
- `xf_f` out 2×16: transform operand.
- `xf_valid_in` out 1: transform input strobe.
- `xf_result` in 2×32: signed integer coordinates; [1]=x column, [0]=y row, already y-flipped.
- `xf_valid_out` in 1: transform result strobe. Cannot be stalled.
- `fb_addr` out FB_ADDR_WIDTH: framebuffer write address.
- `fb_data` out PIXEL_WIDTH: framebuffer write data.
- `fb_we` out 1: write request.
- `fb_ready` in 1: a write transfers on any cycle where `fb_we && fb_ready`.

## Operation
- States: IDLE → CLEAR → ISSUE → DRAIN → DONE → IDLE.
- **IDLE:** on `start`, reset clear address, particle index, `dropped_count` → CLEAR.
- **CLEAR:** `fb_we`=1, `fb_data`=BG_COLOR, `fb_addr` counts 0..SCREEN_W*SCREEN_H-1. The address advances only on transfer. The last transfer → ISSUE.
- **ISSUE:** a read is issued (`pmem_rd_en`=1, `pmem_addr`=index, index++) when `inflight + fifo_count < FIFO_DEPTH`.
  - `inflight` counts reads issued whose transform result has not yet returned. It increments on issue and decrements on `xf_valid_out`. Both in the same cycle leave it unchanged.
  - A RD_LATENCY-deep valid shift register delays each read strobe. Its output drives `xf_valid_in`, and `xf_f`=`pmem_data` in that cycle.
  - After issuing index NUM_PARTICLES-1 → DRAIN.
- **Result path (ISSUE and DRAIN):** every `xf_valid_out` pushes `xf_result` into the FIFO. The credit rule guarantees the FIFO never overflows; an overflow is a bench assertion failure.
  - FIFO head is popped into the write stage. If 0≤x<SCREEN_W and 0≤y<SCREEN_H: `fb_we`=1, `fb_addr`=y*SCREEN_W+x (truncated to FB_ADDR_WIDTH), `fb_data`=FG_COLOR, held until `fb_ready`.
  - Otherwise: no write, `dropped_count`++ (saturating at 16'hFFFF), pop next cycle.
- **DRAIN:** when `inflight`==0, FIFO empty and no pending write → DONE.
- **DONE:** `frame_done`=1 for one cycle → IDLE.
- Coordinates are compared as signed 32-bit values. Negative values are clipped.
- NUM_PARTICLES=0 is unsupported.

## Timing
- Reset values: IDLE; all outputs 0 (`fb_data`=0, `dropped_count`=0). Credit counter, FIFO and shift register are empty.
- Reset mid-frame aborts immediately. Transform results arriving after reset deassertion are ignored in IDLE; the bench must flush the transform before the next `start`.
- `busy` rises the cycle after `start` and falls in the same cycle `frame_done` pulses.
- The first particle read is one cycle after the last clear transfer.
- `xf_valid_in` follows `pmem_rd_en` by exactly RD_LATENCY cycles.
- With `fb_ready` held high, the result path sustains one write per cycle.
- Issue throughput is one per cycle while credits are available.

## Structure
- Shared package `render_pkg`: state enum `render_state_t`, screen size constants, colour defaults.
- Sub-module `result_fifo`: synchronous FIFO, DEPTH×64 bits, with `count` output, simultaneous push/pop allowed when full or empty.
- The top level contains the FSM, credit counter, read-latency shift register, clip/address compute (one multiply by a constant) and write stage.

## Test plan
- Full frame with `fb_ready`=1, 4 particles mapping to (0,0), (319,179), (160,90), (10,20): 57600 BG writes, then FG writes to 0, 57599, 28960, 6410. `frame_done` 1 pulse, `dropped_count`=0.
- Results (−1,5), (320,0), (0,180), (5,5): only address 1605 written; `dropped_count`=3.
- `fb_ready` low for 200 cycles during ISSUE with a 20-cycle transform model: `inflight+fifo_count` never exceeds 8, no lost results, all NUM_PARTICLES handled.
- `start` pulsed while `busy`: ignored, single `frame_done`.
- `rst` asserted mid-CLEAR: all outputs 0 the same cycle. A following `start` runs a complete correct frame.
- Random `fb_ready` with 64 particles: framebuffer contents match the reference model; `xf_valid_in` timing is exactly RD_LATENCY after each read.
